// File: rtl/par2ser_tx.sv
// par2ser_tx: framed MSB-first parallel-to-serial transmitter with a one-word holding register.
// Define PAR2SER_PARITY_EN to append an even-parity bit after the data bits.
module par2ser_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sout,
    output logic             bit_valid,
    output logic             tx_done,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
`ifdef PAR2SER_PARITY_EN
    typedef enum logic [1:0] {IDLE, START, DATA, PAR} state_t;
    logic r_par, w_par_nxt;
`else
    typedef enum logic [1:0] {IDLE, START, DATA} state_t;
`endif
    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_hold, r_shift, w_shift_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic             r_hold_vld, w_accept, w_last, w_load, w_sout_nxt, w_done_nxt;

    assign in_ready = rstn & ~r_hold_vld;
    assign w_accept = in_valid & in_ready;
    assign busy     = (r_state != IDLE) | r_hold_vld;

    // Outputs are registered from the next state, so each state shows its own bit.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_load      = 1'b0;
        w_sout_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
`ifdef PAR2SER_PARITY_EN
        w_par_nxt   = r_par;
        w_last      = (r_state == PAR);
`else
        w_last      = (r_state == DATA) && (r_cnt == '0);
`endif
        if (r_state == IDLE || w_last) begin
            w_load      = r_hold_vld;
            w_state_nxt = r_hold_vld ? START : IDLE;
        end else if (r_state == START) begin
            w_state_nxt = DATA;
            w_cnt_nxt   = CW'(WIDTH - 1);
        end else if (r_state == DATA) begin
            w_cnt_nxt = (r_cnt == '0) ? r_cnt : r_cnt - CW'(1);
`ifdef PAR2SER_PARITY_EN
            if (r_cnt == '0) w_state_nxt = PAR;
`endif
        end
        if (w_load) begin
            w_shift_nxt = r_hold;
`ifdef PAR2SER_PARITY_EN
            w_par_nxt   = ^r_hold;
`endif
        end
        if (w_state_nxt == DATA) begin
            w_sout_nxt  = r_shift[WIDTH-1];
            w_shift_nxt = r_shift << 1;
        end
        if (w_state_nxt == START) w_sout_nxt = 1'b1;
`ifdef PAR2SER_PARITY_EN
        if (w_state_nxt == PAR) w_sout_nxt = r_par;
        w_done_nxt = (w_state_nxt == PAR);
`else
        w_done_nxt = (w_state_nxt == DATA) && (w_cnt_nxt == '0);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_hold     <= '0;
            r_hold_vld <= 1'b0;
            r_shift    <= '0;
            r_cnt      <= '0;
            sout       <= 1'b0;
            bit_valid  <= 1'b0;
            tx_done    <= 1'b0;
`ifdef PAR2SER_PARITY_EN
            r_par      <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_cnt      <= w_cnt_nxt;
            r_hold_vld <= w_accept | (r_hold_vld & ~w_load);
            sout       <= w_sout_nxt;
            bit_valid  <= (w_state_nxt != IDLE);
            tx_done    <= w_done_nxt;
            if (w_accept) r_hold <= in_data;
`ifdef PAR2SER_PARITY_EN
            r_par      <= w_par_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_par2ser_tx.sv
// tb_par2ser_tx: table vectors, corner sequences and random traffic checked against a bit-queue model.
module tb_par2ser_tx;
`ifdef PAR2SER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int FL = PAR ? 10 : 9;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready, sout, bit_valid, tx_done, busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic       q[$];
    logic       m_hold_vld = 1'b0;
    logic [7:0] m_hold = 8'h00;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;
    vec_t tbl[6];

    par2ser_tx #(.WIDTH(8)) dut (
        .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .sout(sout), .bit_valid(bit_valid),
        .tx_done(tx_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %b want %b", name, $time, act, exp);
        end
    endtask

    task automatic cmp_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d want %0d", name, $time, act, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] w);
        q.push_back(1'b1);
        for (int i = 7; i >= 0; i--) q.push_back(w[i]);
        if (PAR) q.push_back(^w);
    endtask

    task automatic model_edge();
        logic acc;
        if (!rstn) begin
            q.delete();
            m_hold_vld = 1'b0;
        end else begin
            acc = in_valid && !m_hold_vld;
            if (q.size() > 0) void'(q.pop_front());
            if (q.size() == 0 && m_hold_vld) begin
                push_frame(m_hold);
                m_hold_vld = 1'b0;
            end
            if (acc) begin
                m_hold     = in_data;
                m_hold_vld = 1'b1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        cmp("sout", sout, q.size() > 0 ? q[0] : 1'b0);
        cmp("bit_valid", bit_valid, q.size() > 0);
        cmp("tx_done", tx_done, q.size() == 1);
        cmp("busy", busy, q.size() > 0 || m_hold_vld);
        cmp("in_ready", in_ready, rstn && !m_hold_vld);
    endtask

    task automatic send(input logic [7:0] w);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int i = 0; i < 100 && !ok; i++) begin
            ok = in_ready;
            step();
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout word %h never accepted", w);
        end
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            done = (q.size() == 0) && !m_hold_vld;
            if (!done) step();
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout model queue %0d hold %b", q.size(), m_hold_vld);
        end
    endtask

    initial begin
        int cnt;
        logic [9:0] f;
        tbl[0] = '{8'hA5, 10'b1_10100101_0};
        tbl[1] = '{8'h3C, 10'b1_00111100_0};
        tbl[2] = '{8'h01, 10'b1_00000001_1};
        tbl[3] = '{8'hFF, 10'b1_11111111_0};
        tbl[4] = '{8'h80, 10'b1_10000000_1};
        tbl[5] = '{8'h00, 10'b1_00000000_0};

        step();
        step();
        cmp("reset_in_ready", in_ready, 1'b0);
        rstn = 1'b1;
        step();

        // Single frames against hand-computed bit patterns
        for (int t = 0; t < 6; t++) begin
            f = tbl[t].frame;
            send(tbl[t].data);
            step();
            for (int i = 0; i < FL; i++) begin
                cmp("tbl_sout", sout, f[9-i]);
                cmp("tbl_bit_valid", bit_valid, 1'b1);
                cmp("tbl_tx_done", tx_done, i == FL - 1);
                step();
            end
            cmp("tbl_idle_sout", sout, 1'b0);
            cmp("tbl_idle_bit_valid", bit_valid, 1'b0);
            drain();
        end

        // Back-to-back frames with no gap
        send(8'hA5);
        send(8'h3C);
        cmp("b2b_in_ready", in_ready, 1'b0);
        cnt = 0;
        while (bit_valid && cnt < 100) begin
            cnt++;
            step();
        end
        cmp_int("b2b_contiguous_bits", cnt, 2 * FL - 1);
        drain();

        // Source holds 0xFF while the holding register is full
        send(8'hA5);
        send(8'h3C);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            step();
            cmp("hold_full_in_ready", in_ready, 1'b0);
        end
        send(8'hFF);
        drain();

        // Reset during data bit 4, with a word waiting in the holding register
        send(8'hA5);
        in_valid = 1'b1;
        in_data  = 8'h3C;
        step();
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        cmp("pre_reset_bit_valid", bit_valid, 1'b1);
        cmp("pre_reset_busy", busy, 1'b1);
        rstn = 1'b0;
        step();
        cmp("rst_sout", sout, 1'b0);
        cmp("rst_bit_valid", bit_valid, 1'b0);
        cmp("rst_busy", busy, 1'b0);
        cmp("rst_in_ready", in_ready, 1'b0);
        rstn = 1'b1;
        step();
        send(8'h01);
        drain();

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            rstn     = ($urandom % 300) != 0;
            in_valid = ($urandom % 4) != 0;
            in_data  = 8'($urandom);
            step();
        end
        rstn     = 1'b1;
        in_valid = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/par2ser_tx.md
PAR2SER_TX -- requirements
Module: par2ser_tx

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8: number of data bits per word, with 2 <= WIDTH <= 32.
REQ-002 The block SHALL provide clk  input  1  system clock; all state updates on its rising edge.
REQ-003 The block SHALL provide rstn  input  1  reset, synchronous, active-low.
REQ-004 The block SHALL provide in_data  input  WIDTH  parallel word to serialize.
REQ-005 The block SHALL provide in_valid  input  1  in_data is valid this cycle.
REQ-006 The block SHALL provide in_ready  output  1  block can accept a word this cycle.
REQ-007 The block SHALL provide sout  output  1  registered serial bit stream, which is the input to the downstream delay line.
REQ-008 The block SHALL provide bit_valid  output  1  registered flag, high while sout carries a frame bit.
REQ-009 The block SHALL provide tx_done  output  1  registered one-cycle pulse, coincident with the last frame bit on sout.
REQ-010 The block SHALL provide busy  output  1  high when the engine is not IDLE or the holding register is full.

Function
REQ-011 A word SHALL be accepted on a rising edge where in_valid and in_ready are both high; in_ready SHALL equal the inverse of hold_vld (one-word holding register).
REQ-012 On acceptance, the block SHALL capture in_data into the holding register and set hold_vld.
REQ-013 The engine FSM SHALL have states IDLE, START, DATA and PAR; PAR SHALL exist only when PARITY_EN is defined.
REQ-014 In IDLE with hold_vld high, the next edge SHALL load the shift register from the holding register, clear hold_vld and enter START.
REQ-015 START SHALL drive sout=1 with bit_valid=1 for one cycle, then enter DATA.
REQ-016 DATA SHALL emit the WIDTH bits MSB first, one per cycle, using a bit counter that runs from WIDTH-1 down to 0.
REQ-017 After the last data bit, the FSM SHALL go to PAR if PARITY_EN is defined, otherwise it SHALL end the frame.
REQ-018 PAR SHALL emit the even-parity bit (XOR of the word's bits) for one cycle.
REQ-019 At frame end, if hold_vld is high, the FSM SHALL load the next word and enter START with zero idle cycles; otherwise it SHALL enter IDLE.
REQ-020 In IDLE, sout SHALL be 0 and bit_valid SHALL be 0.
REQ-021 Latency: a word accepted at edge k SHALL have its start bit on sout during the cycle after edge k+1 (2 cycles).
REQ-022 Frame length SHALL be WIDTH+1 cycles without parity and WIDTH+2 cycles with parity; sustained throughput SHALL be one word per frame length.
REQ-023 The holding register SHALL refill during a frame; a word accepted during a frame SHALL NOT disturb the word being shifted.
REQ-024 While hold_vld is high, in_data and in_valid SHALL be ignored, and a word held by the source SHALL be accepted later without loss.
REQ-025 tx_done SHALL be high only during the final bit of each frame (the last data bit, or the parity bit when parity is enabled).

Reset
REQ-026 While rstn is low at a rising edge, the FSM SHALL go to IDLE, hold_vld to 0, and the bit counter and shift register to 0.
REQ-027 While rstn is low at a rising edge, sout, bit_valid and tx_done SHALL go to 0.
REQ-028 in_ready SHALL be held 0 while rstn is low.
REQ-029 Reset mid-frame SHALL abort the frame with no partial bits after the reset edge; the holding register content SHALL be discarded.

Configuration
REQ-030 Macro PAR2SER_PARITY_EN: when defined, the PAR state and even-parity bit SHALL be present (frame = 1+WIDTH+1); when undefined, PAR logic SHALL be absent and frames SHALL be 1+WIDTH bits.

Verification
REQ-031 WIDTH=8, PARITY_EN defined, send 0xA5 -> sout = 1,1,0,1,0,0,1,0,1,0 with bit_valid high for 10 cycles, and tx_done on the 10th.
REQ-032 Without PARITY_EN, send 0x3C -> sout = 1,0,0,1,1,1,1,0,0 over 9 cycles, then 0 with bit_valid low.
REQ-033 Back-to-back 0xA5 then 0x3C with in_valid held -> the second start bit immediately follows the first frame's last bit; in_ready drops after the second acceptance.
REQ-034 in_valid held high with word 0xFF while the holding register is full -> in_ready=0, and 0xFF is transmitted intact after the current frame.
REQ-035 rstn low for one edge during the DATA bit 4 of 0xA5 -> sout=0, bit_valid=0, busy=0 after that edge; a new 0x01 then frames correctly.
